mmc1_writer: RTL and testbench

MMC1_WRITER -- requirements
Module: mmc1_writer

---
 rtl/mmc1_writer.sv | 172 +++++++++++++++++
 tb/tb_mmc1_writer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mmc1_writer.sv
// mmc1_writer: serial-write sequencer for an MMC1-style mapper register, with shadow copies.
// Latency: first bus write the cycle after acceptance; done at 2+(4+r)*(GAP_CYCLES+1); ready again at 1+(5+r)*(GAP_CYCLES+1).
// Backpressure: req_ready only in IDLE; a request held high is accepted the cycle IDLE is re-entered.
//
// Ports:
//   CPU_M2, nRESET                      clock, synchronous active-low reset
//   req_valid/req_ready                 request handshake
//   req_reg, req_data, req_reset        target register, 5-bit value, precede with shift-reset write
//   done                                one-cycle completion pulse
//   CPU_A14/A13, nCPU_ROMSEL, nCPU_RW,  CPU bus towards the mapper
//   CPU_D7, CPU_D0
//   shadow_ctrl/chr0/chr1/prg           model of the mapper's internal registers
module mmc1_writer #(
  parameter int GAP_CYCLES = 1
) (
  input  logic       CPU_M2,
  input  logic       nRESET,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_reg,
  input  logic [4:0] req_data,
  input  logic       req_reset,
  output logic       done,
  output logic       CPU_A14,
  output logic       CPU_A13,
  output logic       nCPU_ROMSEL,
  output logic       nCPU_RW,
  output logic       CPU_D7,
  output logic       CPU_D0,
  output logic [4:0] shadow_ctrl,
  output logic [4:0] shadow_chr0,
  output logic [4:0] shadow_chr1,
  output logic [4:0] shadow_prg
);

  typedef enum logic [2:0] {IDLE, RST_WR, RST_GAP, BIT_WR, BIT_GAP} state_t;

  // Gap counter holds the number of gap cycles still to follow the current one.
  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);
  localparam logic [4:0] CTRL_RST = 5'b01100;

  state_t     r_state;
  logic [1:0] r_reg;
  logic [4:0] r_data;
  logic [2:0] r_bit;
  logic [3:0] r_gap;
  logic       r_ready;
  logic       r_done;
  logic [1:0] r_addr;
  logic       r_romsel_n;
  logic       r_rw_n;
  logic       r_d7;
  logic       r_d0;
  logic [4:0] r_sh_ctrl;
  logic [4:0] r_sh_chr0;
  logic [4:0] r_sh_chr1;
  logic [4:0] r_sh_prg;

  logic [2:0] w_bit_nxt;
  assign w_bit_nxt = r_bit + 3'd1;

  always_ff @(posedge CPU_M2) begin
    if (!nRESET) begin
      r_state    <= IDLE;
      r_bit      <= 3'd0;
      r_gap      <= 4'd0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_addr     <= 2'b00;
      r_romsel_n <= 1'b1;
      r_rw_n     <= 1'b1;
      r_d7       <= 1'b0;
      r_d0       <= 1'b0;
      r_sh_ctrl  <= CTRL_RST;
      r_sh_chr0  <= 5'd0;
      r_sh_chr1  <= 5'd0;
      r_sh_prg   <= 5'd0;
    end else begin
      // Outputs are registered alongside the next state; default is a non-write cycle.
      r_done     <= 1'b0;
      r_romsel_n <= 1'b1;
      r_rw_n     <= 1'b1;
      r_d7       <= 1'b0;
      r_d0       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_reg      <= req_reg;
            r_data     <= req_data;
            r_addr     <= req_reg;
            r_ready    <= 1'b0;
            r_bit      <= 3'd0;
            r_romsel_n <= 1'b0;
            r_rw_n     <= 1'b0;
            if (req_reset) begin
              r_state <= RST_WR;
              r_d7    <= 1'b1;
            end else begin
              r_state <= BIT_WR;
              r_d0    <= req_data[0];
            end
          end
        end
        RST_WR: begin
          r_state   <= RST_GAP;
          r_gap     <= GAP_LOAD;
          // The mapper's reset write forces PRG mode bits in its control register.
          r_sh_ctrl <= r_sh_ctrl | CTRL_RST;
        end
        BIT_WR: begin
          r_state <= BIT_GAP;
          r_gap   <= GAP_LOAD;
          if (r_bit == 3'd4) begin
            r_done <= 1'b1;
            case (r_reg)
              2'd0:    r_sh_ctrl <= r_data;
              2'd1:    r_sh_chr0 <= r_data;
              2'd2:    r_sh_chr1 <= r_data;
              default: r_sh_prg  <= r_data;
            endcase
          end
        end
        RST_GAP: begin
          if (r_gap == 4'd0) begin
            r_state    <= BIT_WR;
            r_bit      <= 3'd0;
            r_romsel_n <= 1'b0;
            r_rw_n     <= 1'b0;
            r_d0       <= r_data[0];
          end else begin
            r_gap <= r_gap - 4'd1;
          end
        end
        BIT_GAP: begin
          if (r_gap != 4'd0) begin
            r_gap <= r_gap - 4'd1;
          end else if (r_bit == 3'd4) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_addr  <= 2'b00;
            r_bit   <= 3'd0;
          end else begin
            r_state    <= BIT_WR;
            r_bit      <= w_bit_nxt;
            r_romsel_n <= 1'b0;
            r_rw_n     <= 1'b0;
            r_d0       <= r_data[w_bit_nxt];
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_addr  <= 2'b00;
        end
      endcase
    end
  end

  assign req_ready   = r_ready;
  assign done        = r_done;
  assign CPU_A14     = r_addr[1];
  assign CPU_A13     = r_addr[0];
  assign nCPU_ROMSEL = r_romsel_n;
  assign nCPU_RW     = r_rw_n;
  assign CPU_D7      = r_d7;
  assign CPU_D0      = r_d0;
  assign shadow_ctrl = r_sh_ctrl;
  assign shadow_chr0 = r_sh_chr0;
  assign shadow_chr1 = r_sh_chr1;
  assign shadow_prg  = r_sh_prg;

endmodule

// File: tb/tb_mmc1_writer.sv
// tb_mmc1_writer: directed bench for mmc1_writer with GAP_CYCLES=1 and GAP_CYCLES=3 instances.
// Latency: cycle-by-cycle bus comparison against a cycle-formula model.
// Backpressure: exercises held req_valid across back-to-back requests.
module tb_mmc1_writer;

  logic       CPU_M2 = 1'b0;
  logic       nRESET;
  logic       v1, v3;
  logic [1:0] req_reg;
  logic [4:0] req_data;
  logic       req_reset;

  logic       rdy1, done1, a14_1, a13_1, rs1, rw1, d7_1, d0_1;
  logic [4:0] sc1, s01, s11, sp1;
  logic       rdy3, done3, a14_3, a13_3, rs3, rw3, d7_3, d0_3;
  logic [4:0] sc3, s03, s13, sp3;

  int checks = 0;
  int errors = 0;

  always #5 CPU_M2 = ~CPU_M2;

  mmc1_writer #(.GAP_CYCLES(1)) dut1 (
    .CPU_M2(CPU_M2), .nRESET(nRESET), .req_valid(v1), .req_ready(rdy1),
    .req_reg(req_reg), .req_data(req_data), .req_reset(req_reset), .done(done1),
    .CPU_A14(a14_1), .CPU_A13(a13_1), .nCPU_ROMSEL(rs1), .nCPU_RW(rw1),
    .CPU_D7(d7_1), .CPU_D0(d0_1),
    .shadow_ctrl(sc1), .shadow_chr0(s01), .shadow_chr1(s11), .shadow_prg(sp1)
  );

  mmc1_writer #(.GAP_CYCLES(3)) dut3 (
    .CPU_M2(CPU_M2), .nRESET(nRESET), .req_valid(v3), .req_ready(rdy3),
    .req_reg(req_reg), .req_data(req_data), .req_reset(req_reset), .done(done3),
    .CPU_A14(a14_3), .CPU_A13(a13_3), .nCPU_ROMSEL(rs3), .nCPU_RW(rw3),
    .CPU_D7(d7_3), .CPU_D0(d0_3),
    .shadow_ctrl(sc3), .shadow_chr0(s03), .shadow_chr1(s13), .shadow_prg(sp3)
  );

  // Bus snapshot: {ready, done, romsel_n, rw_n, a14, a13, d7, d0}
  logic [7:0]  bus1, bus3;
  logic [19:0] sh1, sh3;
  assign bus1 = {rdy1, done1, rs1, rw1, a14_1, a13_1, d7_1, d0_1};
  assign bus3 = {rdy3, done3, rs3, rw3, a14_3, a13_3, d7_3, d0_3};
  assign sh1  = {sc1, s01, s11, sp1};
  assign sh3  = {sc3, s03, s13, sp3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CPU_M2);
    #1;
  endtask

  // Expected bus in cycle c (cycle 0 = acceptance) from the write-schedule formula.
  function automatic logic [7:0] exp_bus(input int g, input logic [1:0] rg, input logic [4:0] d,
                                         input logic r, input int c);
    logic [7:0] e;
    int p, rc, dn, ri;
    ri = r ? 1 : 0;
    p  = g + 1;
    rc = 1 + (5 + ri) * p;
    dn = 2 + (4 + ri) * p;
    if (c >= rc) return 8'hB0;
    e = {1'b0, (c == dn), 1'b1, 1'b1, rg, 2'b00};
    if (r && c == 1) begin
      e[5:4] = 2'b00;
      e[1]   = 1'b1;
    end
    for (int k = 0; k < 5; k++) begin
      if (c == 1 + (k + ri) * p) begin
        e[5:4] = 2'b00;
        e[0]   = d[k];
      end
    end
    return e;
  endfunction

  // Runs one transaction on the selected instance and checks every cycle to ready.
  task automatic txn(input int g, input logic [1:0] rg, input logic [4:0] d, input logic r,
                     input logic [4:0] ctrl_c2);
    int rc;
    rc = 1 + (5 + (r ? 1 : 0)) * (g + 1);
    chk("pre_ready", (g == 1) ? rdy1 : rdy3, 1'b1);
    req_reg = rg; req_data = d; req_reset = r;
    if (g == 1) v1 = 1'b1; else v3 = 1'b1;
    step();
    v1 = 1'b0; v3 = 1'b0;
    // Busy-time input changes must be ignored.
    req_reg = ~rg; req_data = ~d; req_reset = ~r;
    for (int c = 1; c <= rc; c++) begin
      chk($sformatf("g%0d_bus_c%0d", g, c), (g == 1) ? bus1 : bus3, exp_bus(g, rg, d, r, c));
      if (r && c == 2) chk("ctrl_after_rst", (g == 1) ? sc1 : sc3, ctrl_c2);
      if (c < rc) step();
    end
  endtask

  initial begin
    int n;
    nRESET = 1'b0; v1 = 1'b0; v3 = 1'b0;
    req_reg = 2'd0; req_data = 5'd0; req_reset = 1'b0;
    step(); step();
    nRESET = 1'b1;
    step();
    chk("rst_bus1", bus1, 8'hB0);
    chk("rst_bus3", bus3, 8'hB0);
    chk("rst_sh1", sh1, {5'h0C, 5'h00, 5'h00, 5'h00});

    // PRG load, no reset write
    txn(1, 2'd3, 5'h15, 1'b0, 5'h0C);
    chk("prg_15", sh1, {5'h0C, 5'h00, 5'h00, 5'h15});

    // Control load preceded by a reset write
    txn(1, 2'd0, 5'h03, 1'b1, 5'h0C);
    chk("ctrl_03", sh1, {5'h03, 5'h00, 5'h00, 5'h15});

    // Reset write ORs into an existing control value
    txn(1, 2'd0, 5'h11, 1'b1, 5'h0F);
    chk("ctrl_11", sh1, {5'h11, 5'h00, 5'h00, 5'h15});

    // Wider gap
    txn(3, 2'd1, 5'h1F, 1'b0, 5'h0C);
    chk("chr0_1f_g3", s03, 5'h1F);

    // Back-to-back with req_valid held high
    req_reg = 2'd2; req_data = 5'h09; req_reset = 1'b0; v1 = 1'b1;
    step();
    req_reg = 2'd1; req_data = 5'h16; req_reset = 1'b0;
    for (int c = 2; c <= 11; c++) step();
    chk("b2b_ready_c11", rdy1, 1'b1);
    chk("b2b_chr1", s11, 5'h09);
    step();
    v1 = 1'b0;
    chk("b2b_wr_c12", bus1, 8'h04);
    n = 0;
    while (!rdy1 && n < 40) begin
      step();
      n++;
    end
    chk("b2b_ready_c22", n, 10);
    chk("b2b_chr0", s01, 5'h16);

    // Reset in cycle 4 of a PRG load
    req_reg = 2'd3; req_data = 5'h0A; req_reset = 1'b0; v1 = 1'b1;
    step();
    v1 = 1'b0;
    step(); step(); step();
    nRESET = 1'b0;
    step();
    chk("mid_rst_bus", bus1[6:0], 7'h30);
    chk("mid_rst_sh", sh1, {5'h0C, 5'h00, 5'h00, 5'h00});
    nRESET = 1'b1;
    step();
    chk("post_rst_bus", bus1, 8'hB0);
    for (int c = 0; c < 12; c++) begin
      step();
      chk($sformatf("post_rst_idle_%0d", c), bus1, 8'hB0);
    end
    chk("post_rst_sh", sh1, {5'h0C, 5'h00, 5'h00, 5'h00});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
